// File: rtl/apb_sample_fifo_pkg.sv
// Shared register map, bit positions and FSM encoding for the APB sample FIFO.
package apb_sample_fifo_pkg;

   localparam logic [7:0] ADDR_DATA   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h04;
   localparam logic [7:0] ADDR_COUNT  = 8'h08;
   localparam logic [7:0] ADDR_CTRL   = 8'h0C;

   localparam int STAT_EMPTY = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_OVF   = 2;

   localparam int CTRL_FLUSH   = 0;
   localparam int CTRL_CLR_OVF = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/sample_fifo_core.sv
// Synchronous FIFO: push, pop, flush, fill count; head word is read through a register.
module sample_fifo_core #(
   parameter  int DEPTH  = 8,
   parameter  int DATA_W = 32,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] head_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              full_o,
   output logic              empty_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] head_q;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage has no reset so it maps onto RAM; the head is re-read every cycle.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
      head_q <= mem_q[rd_ptr_q];
   end

   assign head_o  = head_q;
   assign count_o = count_q;

endmodule

// File: rtl/apb_sample_fifo.sv
// APB target buffering sampler writes in a FIFO; DATA/STATUS/COUNT/CTRL registers, one wait state.
module apb_sample_fifo
   import apb_sample_fifo_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8,
   parameter int THRESH = 4
) (
   input  logic                     pclk_i,
   input  logic                     preset_i,
   input  logic                     psel_i,
   input  logic                     penable_i,
   input  logic                     pwrite_i,
   input  logic [ADDR_W-1:0]        paddr_i,
   input  logic [DATA_W-1:0]        pwdata_i,
   output logic [DATA_W-1:0]        prdata_o,
   output logic                     pready_o,
   output logic                     pslverr_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     irq_o
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] prdata_q, rdata_d;
   logic              pslverr_q, err_d;
   logic              ovf_q;

   logic [DATA_W-1:0] fifo_head;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full, fifo_empty;
   logic              is_data, is_status, is_count, is_ctrl;
   logic              resp, data_wr, push, pop, ctrl_wr, flush;

   assign is_data   = (addr_q == ADDR_W'(ADDR_DATA));
   assign is_status = (addr_q == ADDR_W'(ADDR_STATUS));
   assign is_count  = (addr_q == ADDR_W'(ADDR_COUNT));
   assign is_ctrl   = (addr_q == ADDR_W'(ADDR_CTRL));

   // Response is decided during WAIT; FIFO state cannot change before RESP commits.
   always_comb begin
      err_d   = 1'b1;
      rdata_d = '0;
      if (is_data) begin
         if (write_q) begin
            err_d = fifo_full;
         end else begin
            err_d = fifo_empty;
            if (!fifo_empty) rdata_d = fifo_head;
         end
      end else if (is_status) begin
         err_d = write_q;
         if (!write_q) begin
            rdata_d[STAT_EMPTY] = fifo_empty;
            rdata_d[STAT_FULL]  = fifo_full;
            rdata_d[STAT_OVF]   = ovf_q;
         end
      end else if (is_count) begin
         err_d = write_q;
         if (!write_q) rdata_d = DATA_W'(fifo_count);
      end else if (is_ctrl) begin
         err_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (psel_i && !penable_i) state_d = ST_WAIT;
         ST_WAIT: state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign resp    = (state_q == ST_RESP);
   assign data_wr = resp && write_q && is_data;
   assign push    = data_wr && !pslverr_q;
   assign pop     = resp && !write_q && is_data && !pslverr_q;
   assign ctrl_wr = resp && write_q && is_ctrl && !pslverr_q;
   assign flush   = ctrl_wr && wdata_q[CTRL_FLUSH];

   always_ff @(posedge pclk_i or posedge preset_i) begin
      if (preset_i) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && psel_i && !penable_i) begin
            addr_q  <= paddr_i;
            write_q <= pwrite_i;
            wdata_q <= pwdata_i;
         end
         if (state_q == ST_WAIT) begin
            prdata_q  <= rdata_d;
            pslverr_q <= err_d;
         end else begin
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
         end
         // The only error on a DATA write is a full FIFO, which is what overflow records.
         if (data_wr && pslverr_q)
            ovf_q <= 1'b1;
         else if (ctrl_wr && wdata_q[CTRL_CLR_OVF])
            ovf_q <= 1'b0;
      end
   end

   sample_fifo_core #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_core (
      .clk_i   (pclk_i),
      .rst_i   (preset_i),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .wdata_i (wdata_q),
      .head_o  (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign prdata_o  = prdata_q;
   assign pready_o  = resp;
   assign pslverr_o = pslverr_q;
   assign count_o   = fifo_count;
   assign irq_o     = (fifo_count >= CNT_W'(THRESH));

endmodule

// File: tb/tb_apb_sample_fifo.sv
// Directed bench: APB tasks queue expected responses, a negedge monitor compares them on pready.
module tb_apb_sample_fifo;

   logic        pclk = 1'b0;
   logic        preset;
   logic        psel, penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata_o;
   logic        pready_o, pslverr_o;
   logic [3:0]  count_o;
   logic        irq_o;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [31:0] rd;
      logic        err;
   } exp_t;
   exp_t exp_q[$];

   apb_sample_fifo #(
      .DEPTH(8), .DATA_W(32), .ADDR_W(8), .THRESH(4)
   ) dut (
      .pclk_i    (pclk),
      .preset_i  (preset),
      .psel_i    (psel),
      .penable_i (penable),
      .pwrite_i  (pwrite),
      .paddr_i   (paddr),
      .pwdata_i  (pwdata),
      .prdata_o  (prdata_o),
      .pready_o  (pready_o),
      .pslverr_o (pslverr_o),
      .count_o   (count_o),
      .irq_o     (irq_o)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Monitor: every completed transfer must match the oldest queued expectation.
   always @(negedge pclk) begin
      if (pready_o) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_pready: got pready with empty scoreboard");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("prdata", prdata_o, e.rd);
            check("pslverr", {31'b0, pslverr_o}, {31'b0, e.err});
            $display("xfer done: prdata=0x%08h pslverr=%0d", prdata_o, pslverr_o);
         end
      end
   end

   // Called and returns at #1 after a rising edge.
   task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
      int cyc;
      exp_q.push_back('{rd: exp_rd, err: exp_err});
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
      @(posedge pclk); #1;
      penable = 1'b1;
      cyc = 1;
      while (!pready_o && cyc < 8) begin
         @(posedge pclk); #1;
         cyc++;
      end
      check("latency", 32'(cyc), 32'd2);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic wr_data(input logic [31:0] d, input logic err);
      apb(1'b1, 8'h00, d, 32'h0, err);
   endtask

   task automatic rd_reg(input logic [7:0] a, input logic [31:0] exp, input logic err);
      apb(1'b0, a, 32'h0, exp, err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      repeat (2) @(posedge pclk);
      #1 preset = 1'b0;
      @(posedge pclk); #1;
      check("rst_prdata", prdata_o, 32'h0);
      check("rst_pready", {31'b0, pready_o}, 32'h0);
      check("rst_pslverr", {31'b0, pslverr_o}, 32'h0);
      check("rst_count", 32'(count_o), 32'h0);
      check("rst_irq", {31'b0, irq_o}, 32'h0);

      // Single write, status, drain
      wr_data(32'h2, 1'b0);
      check("count_single", 32'(count_o), 32'd1);
      rd_reg(8'h04, 32'h0, 1'b0);
      rd_reg(8'h00, 32'h2, 1'b0);

      // Fill 8, irq rises on the 4th write
      for (int i = 0; i < 8; i++) begin
         wr_data(32'h10 + 32'(i), 1'b0);
         check("irq_fill", {31'b0, irq_o}, 32'(i + 1 >= 4));
      end
      check("count_full", 32'(count_o), 32'd8);
      rd_reg(8'h04, 32'h2, 1'b0);
      for (int i = 0; i < 8; i++) begin
         rd_reg(8'h00, 32'h10 + 32'(i), 1'b0);
         check("irq_drain", {31'b0, irq_o}, 32'(7 - i >= 4));
      end
      rd_reg(8'h04, 32'h1, 1'b0);

      // Overflow: 9th write dropped
      for (int i = 0; i < 8; i++) wr_data(32'h20 + 32'(i), 1'b0);
      wr_data(32'hAA, 1'b1);
      check("count_ovf", 32'(count_o), 32'd8);
      rd_reg(8'h04, 32'h6, 1'b0);
      for (int i = 0; i < 8; i++) rd_reg(8'h00, 32'h20 + 32'(i), 1'b0);
      rd_reg(8'h04, 32'h5, 1'b0);

      // Error paths
      rd_reg(8'h00, 32'h0, 1'b1);
      rd_reg(8'h20, 32'h0, 1'b1);
      rd_reg(8'h0C, 32'h0, 1'b0);
      apb(1'b1, 8'h04, 32'hFFFF_FFFF, 32'h0, 1'b1);
      apb(1'b1, 8'h08, 32'h3, 32'h0, 1'b1);
      rd_reg(8'h08, 32'h0, 1'b0);
      rd_reg(8'h04, 32'h5, 1'b0);

      // Flush + clear overflow together
      for (int i = 0; i < 5; i++) wr_data(32'h30 + 32'(i), 1'b0);
      check("count_5", 32'(count_o), 32'd5);
      check("irq_5", {31'b0, irq_o}, 32'h1);
      apb(1'b1, 8'h0C, 32'h3, 32'h0, 1'b0);
      check("count_flush", 32'(count_o), 32'd0);
      check("irq_flush", {31'b0, irq_o}, 32'h0);
      rd_reg(8'h04, 32'h1, 1'b0);

      // Fill/drain rounds walk the pointers around the wrap
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 3; k++) wr_data(32'h60 + 32'(r * 4 + k), 1'b0);
         for (int k = 0; k < 3; k++) rd_reg(8'h00, 32'h60 + 32'(r * 4 + k), 1'b0);
      end
      wr_data(32'h55, 1'b0);
      rd_reg(8'h00, 32'h55, 1'b0);
      rd_reg(8'h08, 32'h0, 1'b0);

      // Reset during WAIT of a write
      wr_data(32'h70, 1'b0);
      wr_data(32'h71, 1'b0);
      check("count_pre_rst", 32'(count_o), 32'd2);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h77;
      @(posedge pclk); #1;
      penable = 1'b1;
      preset = 1'b1;
      #1;
      check("midrst_pready", {31'b0, pready_o}, 32'h0);
      check("midrst_count", 32'(count_o), 32'h0);
      check("midrst_irq", {31'b0, irq_o}, 32'h0);
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      preset = 1'b0;
      @(posedge pclk); #1;
      wr_data(32'h99, 1'b0);
      check("count_post_rst", 32'(count_o), 32'd1);
      rd_reg(8'h00, 32'h99, 1'b0);

      repeat (2) @(posedge pclk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/apb_sample_fifo.md
Name: apb_sample_fifo

Overview:
- APB slave that consumes the periodic write transfers issued by the sampler (APB master) and buffers each sample in a FIFO.
- Software or a downstream master drains the samples over the same APB port.
- Exposes status, fill count and a threshold interrupt.
- Sits directly on the sampler's APB bus as its target.

Parameters:
DEPTH, 8, FIFO entries (power of 2, >=2)
DATA_W, 32, sample/data width
ADDR_W, 8, APB address width
THRESH, 4, irq_o asserts when count >= THRESH (1..DEPTH)

Ports:
pclk_i  in  1  clock, all logic on rising edge
preset_i  in  1  asynchronous, active-high reset
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  1=write, 0=read
paddr_i  in  ADDR_W  byte address
pwdata_i  in  DATA_W  write data
prdata_o  out  DATA_W  read data, valid when pready_o=1
pready_o  out  1  transfer complete
pslverr_o  out  1  error, valid when pready_o=1
count_o  out  $clog2(DEPTH)+1  current fill level
irq_o  out  1  count_o >= THRESH

Behaviour:
- Reset (async, preset_i=1): FSM IDLE, FIFO empty, overflow flag 0, prdata_o=0, pready_o=0, pslverr_o=0, count_o=0, irq_o=0.
- Register map (paddr_i):
  - 0x00 DATA: write pushes pwdata_i; read pops the head.
  - 0x04 STATUS (RO): bit0 empty, bit1 full, bit2 overflow (sticky); other bits 0.
  - 0x08 COUNT (RO): zero-extended count.
  - 0x0C CTRL (WO): bit0 flush, bit1 clear overflow; reads return 0 with no error.
  - Any other address: pslverr_o=1, no side effect.
  - Writes to STATUS or COUNT: pslverr_o=1, no side effect.
- FSM states:
  - IDLE: on psel_i & !penable_i (SETUP) -> WAIT.
  - WAIT: first ACCESS cycle; pready_o=0 (one fixed wait state) -> RESP.
  - RESP: pready_o=1 for exactly one cycle; prdata_o and pslverr_o are valid -> IDLE.
  - Access latency is therefore SETUP + 2 cycles. The sampler tolerates this because it holds its outputs until pready.
- Address, direction and write data are captured at SETUP. Side effects (push, pop, flush, clear) commit on the RESP cycle only, and only when pslverr_o=0.
- Write DATA when full: pslverr_o=1, sample dropped, overflow set to 1, count unchanged.
- Read DATA when empty: pslverr_o=1, prdata_o=0, no pointer change.
- Flush and clear overflow written together: both take effect; count becomes 0 and overflow becomes 0.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH. Full/empty are derived from count. Push and pop can never coincide because there is a single port.
- psel_i dropping while in WAIT: the transfer is still completed (RESP is issued) with no special handling. This is a protocol violation by the master.
- preset_i asserted mid-transfer: transfer aborted, FIFO cleared, outputs take reset values immediately.
- prdata_o returns to 0 in IDLE.
- irq_o is combinational from count. It updates the cycle after the commit.

Decomposition:
- Package apb_sample_fifo_pkg holds:
  - register offsets (ADDR_DATA, ADDR_STATUS, ADDR_COUNT, ADDR_CTRL);
  - STATUS bit indices;
  - CTRL bit indices;
  - FSM state enum (IDLE, WAIT, RESP).
- One sub-module, sample_fifo_core: synchronous FIFO with push, pop, flush, count, full and empty. The APB decode and FSM stay in the top level.

Test Plan:
- Reset, then single write DATA=0x2 -> pready_o high exactly 2 cycles after SETUP, pslverr_o=0, count_o=1, STATUS reads 0x0.
- Write 0x10..0x17 (8 samples), then read DATA 8 times -> returns 0x10..0x17 in order; STATUS=0x1 after the last read. irq_o rises after the 4th write and falls after the 5th read.
- 9th write while full (value 0xAA) -> pslverr_o=1, count stays 8, STATUS=0x6. Reading back yields no 0xAA.
- Read DATA when empty -> pslverr_o=1, prdata_o=0. Read of address 0x20 -> pslverr_o=1.
- Fill 5 entries, then write CTRL=0x3 -> count_o=0, STATUS=0x1, irq_o=0. The next write of 0x55 is read back as 0x55 (pointer wrap verified after 3 fill/drain rounds).
- Assert preset_i during the WAIT state of a write -> pready_o=0 and count_o=0 immediately. After release, the next transfer completes normally.
